hht_control: RTL and testbench
==============================

Name: hht_control

Overview:
- Sequencing/datapath controller for the HHT 1-D filter stage.
- After reset it fetches V_SIZE coefficients from a coefficient memory on port 2.
- It then streams csize column samples from a data memory on port 1 and emits one V_SIZE-tap weighted sum per full window.
- Sits between two combinational-read memories and the downstream result buffer.

Parameters:
- V_SIZE, 9, number of coefficients/taps (window length).
- DW, 32, data, address and result width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous active-low reset.
- v_values_base  input  32  base address of coefficients in memory 2; sampled on leaving IDLE.
- wdata_col_base  input  32  base address of column samples in memory 1; sampled on leaving IDLE.
- addr1  output  32  data-memory read address (registered).
- addr2  output  32  coefficient-memory read address (registered).
- dataIn1  input  32  memory-1 read data; combinational from addr1, valid same cycle.
- dataIn2  input  32  memory-2 read data; combinational from addr2, valid same cycle.
- csize  input  32  number of column samples; sampled on leaving IDLE.
- RD  input  1  run enable; high = advance, low = stall.
- dataOut  output  32  filter result (registered).
- out_valid  output  1  one-cycle pulse, dataOut valid.
- done  output  1  high once the column is finished.

Behaviour:
- Reset (Rst=0, async): state=IDLE; addr1=addr2=0; dataOut=0; out_valid=0; done=0; coefficient regs, window regs and counters =0.
- States: IDLE, LOAD_V, STREAM, DONE.
- IDLE -> LOAD_V on first clock with RD=1:
  - latch bases and csize;
  - addr2 <= v_values_base; i <= 0.
- LOAD_V, each RD=1 cycle:
  - coef[i] <= dataIn2; i <= i+1; addr2 <= addr2+1.
  - After coef[V_SIZE-1] is captured: addr2 <= 0, addr1 <= wdata_col_base, j <= 0, go STREAM.
  - LOAD_V therefore lasts exactly V_SIZE cycles.
- STREAM, each RD=1 cycle:
  - shift window: w[k] <= w[k-1], w[0] <= dataIn1; j <= j+1; addr1 <= addr1+1.
  - When sample index j >= V_SIZE-1: next edge registers dataOut = sum over k of coef[k]*w[k], where w[k] is sample j-k, and pulses out_valid.
  - First result one cycle after addr1 = base+V_SIZE-1.
  - Results per column: csize-V_SIZE+1; none if csize < V_SIZE.
- After sample j=csize-1 is taken: addr1 <= 0, go DONE. csize=0 goes LOAD_V -> DONE directly.
- DONE: done=1 and held; outputs frozen until reset.
- Arithmetic: unsigned 32x32 products, accumulation modulo 2^32 (wraps).
- RD=0 in LOAD_V/STREAM: all regs hold, addresses held, out_valid=0; resumes without loss when RD returns.
- Reset mid-operation aborts immediately to the reset state.
- Base/csize changes after leaving IDLE are ignored.

Optional Feature:
- Macro HHT_CTRL_SAT_EN.
- Defined: products and sum use a 64-bit accumulator; dataOut saturates to 32'hFFFF_FFFF on overflow.
- Undefined: modulo-2^32 wrap as above.

Test Plan:
- Reset release, RD=1, v_values_base=2 with coefs 70,58,30,50,22,66,96,54,58; wdata_col_base=340 with samples 10,31,21,24,29,9,20,19,6 -> addr2 steps 2..10, then addr1 steps from 340; first out_valid gives dataOut=9064.
- Same setup, csize=410 -> exactly 402 out_valid pulses; addr1 ends at 749 then returns to 0; done=1 afterwards and stays.
- RD dropped for 5 cycles mid-STREAM -> addr1/dataOut frozen, no out_valid; result sequence identical to the no-stall run.
- csize=5 (< V_SIZE) -> addr1 visits 340..344, zero out_valid pulses, done=1.
- Rst asserted mid-STREAM -> addr1=addr2=0, done=0, out_valid=0 immediately; restart reproduces 9064 as first result.
- All coefs and samples =32'hFFFF_FFFF -> wrapped sum 9 (no macro) / 32'hFFFF_FFFF (HHT_CTRL_SAT_EN).

Source files
------------

// File: rtl/hht_control.sv
// HHT 1-D filter stage controller: fetches V_SIZE coefficients from memory 2, then streams a
// column from memory 1 and emits one V_SIZE-tap weighted sum per full window.
// Optional macro HHT_CTRL_SAT_EN: wide accumulation with dataOut saturating to all-ones.
module hht_control #(
    parameter int V_SIZE = 9,
    parameter int DW     = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] v_values_base,
    input  logic [DW-1:0] wdata_col_base,
    output logic [DW-1:0] addr1,
    output logic [DW-1:0] addr2,
    input  logic [DW-1:0] dataIn1,
    input  logic [DW-1:0] dataIn2,
    input  logic [DW-1:0] csize,
    input  logic          RD,
    output logic [DW-1:0] dataOut,
    output logic          out_valid,
    output logic          done
);

    localparam int IW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_V,
        ST_STREAM,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;

    logic [DW-1:0] addr1_q, addr1_d;
    logic [DW-1:0] addr2_q, addr2_d;
    logic [DW-1:0] wbase_q, wbase_d;
    logic [DW-1:0] csize_q, csize_d;
    logic [DW-1:0] j_q, j_d;
    logic [IW-1:0] i_q, i_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    logic [DW-1:0] coef_q   [V_SIZE];
    logic [DW-1:0] coef_d   [V_SIZE];
    logic [DW-1:0] win_q    [V_SIZE];
    logic [DW-1:0] win_d    [V_SIZE];
    logic [DW-1:0] win_next [V_SIZE];
    logic [DW-1:0] sum;

    logic start, load, shift;
    logic last_coef, emit, last_sample;

    // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (RD) state_d = ST_LOAD_V;
            ST_LOAD_V: if (last_coef) state_d = (csize_q == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: if (last_sample) state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RD gates every phase; a low RD leaves all registers holding.
    always_comb begin
        start = 1'b0;
        load  = 1'b0;
        shift = 1'b0;
        case (state_q)
            ST_IDLE:   start = RD;
            ST_LOAD_V: load  = RD;
            ST_STREAM: shift = RD;
            default:   ;
        endcase
    end

    assign last_coef   = load  && (i_q == IW'(V_SIZE - 1));
    assign emit        = shift && (j_q >= DW'(V_SIZE - 1));
    assign last_sample = shift && (j_q == csize_q - DW'(1));

    // Window as it will be after this shift: the sum covers the sample being taken now.
    always_comb begin
        win_next[0] = dataIn1;
        for (int k = 1; k < V_SIZE; k++) begin
            win_next[k] = win_q[k-1];
        end
    end

`ifdef HHT_CTRL_SAT_EN
    localparam int ACC_W = 2 * DW + $clog2(V_SIZE + 1);
    logic [ACC_W-1:0] acc;

    // Extra headroom above 64 bits keeps the overflow test exact for all-ones operands.
    always_comb begin
        acc = '0;
        for (int k = 0; k < V_SIZE; k++) begin
            acc = acc + ACC_W'(coef_q[k]) * ACC_W'(win_next[k]);
        end
        sum = (|acc[ACC_W-1:DW]) ? '1 : acc[DW-1:0];
    end
`else
    logic [DW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < V_SIZE; k++) begin
            acc = acc + coef_q[k] * win_next[k];
        end
        sum = acc;
    end
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        wbase_d     = wbase_q;
        csize_d     = csize_q;
        j_d         = j_q;
        i_d         = i_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        coef_d      = coef_q;
        win_d       = win_q;

        if (start) begin
            wbase_d = wdata_col_base;
            csize_d = csize;
            addr2_d = v_values_base;
            i_d     = '0;
        end

        if (load) begin
            coef_d[i_q] = dataIn2;
            i_d         = i_q + IW'(1);
            addr2_d     = addr2_q + DW'(1);
            if (last_coef) begin
                addr2_d = '0;
                addr1_d = (csize_q == '0) ? '0 : wbase_q;
                j_d     = '0;
            end
        end

        if (shift) begin
            win_d   = win_next;
            j_d     = j_q + DW'(1);
            addr1_d = addr1_q + DW'(1);
            if (emit) begin
                data_out_d  = sum;
                out_valid_d = 1'b1;
            end
            if (last_sample) begin
                addr1_d = '0;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    // NOTE: coefficient and window arrays are small flop banks, not RAM, so they take the async reset too.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            addr1_q     <= '0;
            addr2_q     <= '0;
            wbase_q     <= '0;
            csize_q     <= '0;
            j_q         <= '0;
            i_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            coef_q      <= '{default: '0};
            win_q       <= '{default: '0};
        end else begin
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            wbase_q     <= wbase_d;
            csize_q     <= csize_d;
            j_q         <= j_d;
            i_q         <= i_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            coef_q      <= coef_d;
            win_q       <= win_d;
        end
    end

    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign dataOut   = data_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hht_control.sv
// Self-checking bench for hht_control: memory models, a window-sum reference model fed by
// directed column runs, and literal expectations for the key results.
module tb_hht_control;

    localparam int V_SIZE = 9;
    localparam int DW     = 32;

    logic          Clk, Rst, RD;
    logic [31:0]   v_values_base, wdata_col_base, csize;
    logic [31:0]   addr1, addr2, dataIn1, dataIn2, dataOut;
    logic          out_valid, done;

    logic [31:0]   mem1 [1024];
    logic [31:0]   mem2 [64];

    assign dataIn1 = mem1[addr1[9:0]];
    assign dataIn2 = mem2[addr2[5:0]];

    hht_control #(.V_SIZE(V_SIZE), .DW(DW)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .v_values_base  (v_values_base),
        .wdata_col_base (wdata_col_base),
        .addr1          (addr1),
        .addr2          (addr2),
        .dataIn1        (dataIn1),
        .dataIn2        (dataIn2),
        .csize          (csize),
        .RD             (RD),
        .dataOut        (dataOut),
        .out_valid      (out_valid),
        .done           (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int          vectors     = 0;
    int          miscompares = 0;
    int          pulses      = 0;
    int          exp_n       = 0;
    logic [31:0] exp_q    [$];
    logic [31:0] got_q    [$];
    logic [31:0] ref_q    [$];
    logic [31:0] a2_trace [$];
    logic [31:0] first_res, first_a1, last_a1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    // Reference: every full window j gives sum_k coef[k] * sample[j-k].
    task automatic build_expected(input int vb, input int wb, input int cs);
        logic [71:0] acc;
        exp_q.delete();
        for (int j = V_SIZE - 1; j < cs; j++) begin
            acc = '0;
            for (int k = 0; k < V_SIZE; k++) begin
                acc += 72'(mem2[vb + k]) * 72'(mem1[wb + j - k]);
            end
`ifdef HHT_CTRL_SAT_EN
            exp_q.push_back((acc > 72'hFFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0]);
`else
            exp_q.push_back(acc[31:0]);
`endif
        end
        exp_n = exp_q.size();
    endtask

    // Compare process: every out_valid pulse is checked against the model in order.
    always @(negedge Clk) begin
        if (Rst && out_valid) begin
            pulses++;
            got_q.push_back(dataOut);
            if (pulses == 1) first_res = dataOut;
            if (exp_q.size() == 0) check("surplus_result", 32'(pulses), 32'(exp_n));
            else                   check("result", dataOut, exp_q.pop_front());
        end
    end

    task automatic run_col(input int vb, input int wb, input int cs,
                           input int stall_at, input int stall_len, input int abort_at);
        int          cyc     = 0;
        int          max_cyc = cs + V_SIZE + stall_len + 40;
        logic [31:0] held_a1, held_do;

        @(negedge Clk);
        Rst            = 1'b0;
        RD             = 1'b0;
        v_values_base  = vb;
        wdata_col_base = wb;
        csize          = cs;
        build_expected(vb, wb, cs);
        pulses    = 0;
        got_q.delete();
        a2_trace.delete();
        first_res = '0;
        first_a1  = '0;
        last_a1   = '0;

        @(negedge Clk);
        check("rst_addr1", addr1, 0);
        check("rst_addr2", addr2, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        Rst     = 1'b1;
        RD      = 1'b1;
        held_a1 = addr1;
        held_do = dataOut;

        while (!done && cyc < max_cyc) begin
            @(negedge Clk);
            cyc++;
            if (!RD) begin
                check("stall_addr1", addr1, held_a1);
                check("stall_dataOut", dataOut, held_do);
                check("stall_out_valid", 32'(out_valid), 0);
            end
            if (addr2 != 0 && (a2_trace.size() == 0 || a2_trace[$] != addr2)) a2_trace.push_back(addr2);
            if (addr1 != 0) begin
                if (first_a1 == 0) first_a1 = addr1;
                last_a1 = addr1;
            end
            if (abort_at != 0 && cyc == abort_at) begin
                #2 Rst = 1'b0;
                #1;
                check("abort_addr1", addr1, 0);
                check("abort_addr2", addr2, 0);
                check("abort_done", 32'(done), 0);
                check("abort_out_valid", 32'(out_valid), 0);
                return;
            end
            RD      = !(cyc >= stall_at && cyc < stall_at + stall_len);
            held_a1 = addr1;
            held_do = dataOut;
        end

        #1;
        check("done_in_budget", 32'(done), 1);
        check("result_count", 32'(pulses), 32'(exp_n));
        check("addr1_after_done", addr1, 0);
        held_do = dataOut;
        for (int n = 0; n < 3; n++) begin
            @(negedge Clk);
            check("done_held", 32'(done), 1);
            check("done_no_pulse", 32'(out_valid), 0);
            check("done_dataOut_frozen", dataOut, held_do);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          diff;
        logic [31:0] coefs   [9] = '{70, 58, 30, 50, 22, 66, 96, 54, 58};
        logic [31:0] samples [9] = '{10, 31, 21, 24, 29, 9, 20, 19, 6};

        Rst = 1'b0;
        RD  = 1'b0;
        v_values_base  = '0;
        wdata_col_base = '0;
        csize          = '0;
        for (int i = 0; i < 1024; i++) mem1[i] = 32'((i * 37 + 11) % 100);
        for (int i = 0; i < 64; i++)   mem2[i] = 32'(i * 3 + 1);
        for (int i = 0; i < 9; i++) begin
            mem2[2 + i]   = coefs[i];
            mem1[340 + i] = samples[i];
            mem2[20 + i]  = 32'hFFFF_FFFF;
            mem1[800 + i] = 32'hFFFF_FFFF;
        end

        // Single window: coefficient fetch, stream addresses and the hand-computed result.
        run_col(2, 340, 9, 0, 0, 0);
        check("first_result", first_res, 9064);
        check("addr2_step_count", 32'(a2_trace.size()), 9);
        check("addr2_first", a2_trace[0], 2);
        check("addr2_last", a2_trace[$], 10);
        check("addr1_first", first_a1, 340);
        check("addr1_last", last_a1, 348);

        // Long column.
        run_col(2, 340, 410, 0, 0, 0);
        check("pulses_410", 32'(pulses), 402);
        check("addr1_last_410", last_a1, 749);
        check("first_result_410", first_res, 9064);
        ref_q = got_q;

        // Same column with a 5-cycle RD stall mid-stream.
        run_col(2, 340, 410, 20, 5, 0);
        check("stall_result_count", 32'(got_q.size()), 32'(ref_q.size()));
        diff = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
            if (got_q[i] !== ref_q[i]) diff++;
        end
        check("stall_sequence_diffs", 32'(diff), 0);

        // Column shorter than the window.
        run_col(2, 340, 5, 0, 0, 0);
        check("short_pulses", 32'(pulses), 0);
        check("short_addr1_first", first_a1, 340);
        check("short_addr1_last", last_a1, 344);

        // Reset mid-stream, then restart.
        run_col(2, 340, 410, 0, 0, 15);
        run_col(2, 340, 9, 0, 0, 0);
        check("restart_first_result", first_res, 9064);

        // Empty column.
        run_col(2, 340, 0, 0, 0, 0);
        check("empty_pulses", 32'(pulses), 0);
        check("empty_addr1_untouched", last_a1, 0);

        // All-ones operands.
        run_col(20, 800, 9, 0, 0, 0);
`ifdef HHT_CTRL_SAT_EN
        check("all_ones_result", first_res, 32'hFFFF_FFFF);
`else
        check("all_ones_result", first_res, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
